lstm_gate_preact: RTL

Parametrised LSTM gate pre-activation unit: streams one input vector x and one hidden-state vector h, element pair per beat, and produces the fixed-point sum W·x + U·h + b. W, U and b are held in a runtime-loadable register file. The unit sits ahead of the sigmoid/tanh activation stage. It generalises the fixed unit-weight two-input weighted adder to vectors, with handshakes, a weight-load port, rounding and saturation.

---
 rtl/lstm_fx_pkg.sv | 27 ++
 rtl/fx_round_sat.sv | 40 ++++
 rtl/lstm_gate_preact.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/lstm_fx_pkg.sv
// Shared fixed-point definitions for the LSTM datapath blocks:
// FSM state encoding, weight-port select codes, constants and width helpers.
package lstm_fx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_FIN,
    ST_OUT
  } state_t;

  localparam logic [1:0] SEL_W = 2'd0;
  localparam logic [1:0] SEL_U = 2'd1;
  localparam logic [1:0] SEL_B = 2'd2;

  localparam logic [63:0] FX_ZERO = 64'd0;

  // 1.0 in a Qm.f format with the given number of fractional bits.
  function automatic logic [63:0] fx_one(input int fract_width);
    return 64'd1 << fract_width;
  endfunction

  function automatic int acc_width(input int data_width, input int vec_len);
    return 2 * data_width + $clog2(2 * vec_len) + 1;
  endfunction

endpackage

// File: rtl/fx_round_sat.sv
// Combinational round-half-up, arithmetic shift by FRACT_WIDTH, then clamp to DATA_WIDTH.
// Clamping is enabled by LSTM_GATE_PREACT_SAT_EN; otherwise the result wraps and sat is 0.
module fx_round_sat #(
  parameter int IN_W        = 36,
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8
) (
  input  logic signed [IN_W-1:0]       din,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic                         sat
);

  // One guard bit keeps the rounding bias from overflowing the input width.
  localparam int EXT_W = IN_W + 1;
  localparam logic signed [EXT_W-1:0] HALF  = EXT_W'(1) <<< (FRACT_WIDTH - 1);
  localparam logic signed [EXT_W-1:0] MAX_V = (EXT_W'(1) <<< (DATA_WIDTH - 1)) - EXT_W'(1);
  localparam logic signed [EXT_W-1:0] MIN_V = -MAX_V - EXT_W'(1);

  logic signed [EXT_W-1:0] shifted;

  assign shifted = (EXT_W'(din) + HALF) >>> FRACT_WIDTH;

`ifdef LSTM_GATE_PREACT_SAT_EN
  always_comb begin
    dout = DATA_WIDTH'(shifted);
    sat  = 1'b0;
    if (shifted > MAX_V) begin
      dout = DATA_WIDTH'(MAX_V);
      sat  = 1'b1;
    end else if (shifted < MIN_V) begin
      dout = DATA_WIDTH'(MIN_V);
      sat  = 1'b1;
    end
  end
`else
  assign dout = DATA_WIDTH'(shifted);
  assign sat  = 1'b0;
`endif

endmodule

// File: rtl/lstm_gate_preact.sv
// LSTM gate pre-activation: streams x/h element pairs and emits round(W.x + U.h + b).
// Output saturation is enabled by defining LSTM_GATE_PREACT_SAT_EN.
module lstm_gate_preact
  import lstm_fx_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int VEC_LEN     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [1:0]                   wr_sel,
  input  logic [$clog2(VEC_LEN)-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         wr_err,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic signed [DATA_WIDTH-1:0] h_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_sat
);

  localparam int ACC_W = acc_width(DATA_WIDTH, VEC_LEN);
  localparam int CNT_W = $clog2(VEC_LEN);
  localparam int PRD_W = 2 * DATA_WIDTH;
  localparam logic signed [DATA_WIDTH-1:0] W_ONE    = DATA_WIDTH'(fx_one(FRACT_WIDTH));
  localparam logic signed [DATA_WIDTH-1:0] W_ZERO   = DATA_WIDTH'(FX_ZERO);
  localparam logic [CNT_W-1:0]             LAST_IDX = CNT_W'(VEC_LEN - 1);

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0] w_q [VEC_LEN];
  logic signed [DATA_WIDTH-1:0] w_d [VEC_LEN];
  logic signed [DATA_WIDTH-1:0] u_q [VEC_LEN];
  logic signed [DATA_WIDTH-1:0] u_d [VEC_LEN];
  logic signed [DATA_WIDTH-1:0] b_q, b_d;
  logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                         out_sat_q, out_sat_d;
  logic                         wr_err_q, wr_err_d;

  logic                         beat;
  logic signed [PRD_W-1:0]      prod_w, prod_u;
  logic signed [ACC_W-1:0]      beat_sum, fin_sum;
  logic signed [DATA_WIDTH-1:0] rs_data;
  logic                         rs_sat;

  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_ACC);
  assign out_valid = (state_q == ST_OUT);
  assign beat      = in_valid && in_ready;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign wr_err    = wr_err_q;

  // Operands are sign-extended to the product width so the low half holds the exact product.
  always_comb begin
    prod_w   = PRD_W'(w_q[cnt_q]) * PRD_W'(x_in);
    prod_u   = PRD_W'(u_q[cnt_q]) * PRD_W'(h_in);
    beat_sum = ACC_W'(prod_w) + ACC_W'(prod_u);
    fin_sum  = acc_q + (ACC_W'(b_q) <<< FRACT_WIDTH);
  end

  fx_round_sat #(
    .IN_W        (ACC_W),
    .DATA_WIDTH  (DATA_WIDTH),
    .FRACT_WIDTH (FRACT_WIDTH)
  ) u_round_sat (
    .din  (fin_sum),
    .dout (rs_data),
    .sat  (rs_sat)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    w_d        = w_q;
    u_d        = u_q;
    b_d        = b_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    wr_err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (beat) begin
          acc_d   = beat_sum;
          cnt_d   = CNT_W'(1);
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (beat) begin
          acc_d = acc_q + beat_sum;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = ST_FIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_FIN: begin
        out_data_d = rs_data;
        out_sat_d  = rs_sat;
        state_d    = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Weights may only change between vectors; the beat on the same edge sees the old value.
    if (wr_en) begin
      if (state_q != ST_IDLE) begin
        wr_err_d = 1'b1;
      end else begin
        case (wr_sel)
          SEL_W: if (int'(wr_addr) < VEC_LEN) w_d[wr_addr] = wr_data;
          SEL_U: if (int'(wr_addr) < VEC_LEN) u_d[wr_addr] = wr_data;
          SEL_B: b_d = wr_data;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      for (int i = 0; i < VEC_LEN; i++) begin
        w_q[i] <= W_ONE;
        u_q[i] <= W_ONE;
      end
      b_q        <= W_ZERO;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      w_q        <= w_d;
      u_q        <= u_d;
      b_q        <= b_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
      wr_err_q   <= wr_err_d;
    end
  end

endmodule
